// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetch requests to instruction
// memory, queues the in-order responses with their PCs, and flushes and
// restarts on redirect. Responses to requests issued before a redirect are
// counted in a drop counter and discarded as they return.
// Optional build macro IFB_STATS_EN adds stat_fetched / stat_flushes counters.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req_valid,
    output logic [31:0]            mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [31:0]            mem_rsp_data,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    input  logic                   out_ready,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] count
`ifdef IFB_STATS_EN
    ,
    output logic [31:0]            stat_fetched,
    output logic [31:0]            stat_flushes
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;      // PC of the next response that will be kept
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;  // accepted requests not yet answered
    logic [CW-1:0] drop_q, drop_d;          // stale responses still to discard
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic        req_fire;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;
    logic [31:0] redirect_pc_aligned;

    // Request/credit handshake and head-of-queue outputs.
    always_comb begin
        credit_used         = {1'b0, count_q} + {1'b0, inflight_q};
        mem_req_valid       = (state_q != IDLE) && !redirect && (credit_used < DEPTH_W);
        mem_req_addr        = fetch_pc_q;
        req_fire            = mem_req_valid && mem_req_ready;
        out_valid           = (count_q != '0);
        // Storage is not reset, so gate the head to read zero while empty.
        out_instr           = out_valid ? instr_mem[head_q] : 32'h0;
        out_pc              = out_valid ? pc_mem[head_q]    : 32'h0;
        pop                 = out_valid && out_ready;
        push                = mem_rsp_valid && (drop_q == '0) && !redirect;
        redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;
        count               = count_q;
    end

    // Next-state logic for the FSM, pointers, occupancy and drop counter.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid);

        if (redirect) begin
            // Everything queued or still in flight belongs to the old path.
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            drop_d     = inflight_q - CW'(mem_rsp_valid);
            state_d    = (drop_d != '0) ? DRAIN : FETCH;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (mem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                tail_d   = tail_q + AW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            case (state_q)
                IDLE:    state_d = FETCH;
                DRAIN:   state_d = (drop_d == '0) ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy alone defines validity.
        if (push) begin
            instr_mem[tail_q] <= mem_rsp_data;
            pc_mem[tail_q]    <= rsp_pc_q;
        end
    end

`ifdef IFB_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_flushes_q, stat_flushes_d;

    // Statistics counters: queued responses and redirects, wrapping at 2^32.
    always_comb begin
        stat_fetched_d = stat_fetched_q + 32'(push);
        stat_flushes_d = stat_flushes_q + 32'(redirect);
        stat_fetched   = stat_fetched_q;
        stat_flushes   = stat_flushes_q;
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched_q <= 32'h0;
            stat_flushes_q <= 32'h0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_flushes_q <= stat_flushes_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: a cycle-stepped memory model
// with programmable latency, a scoreboard of expected queue entries, a phase
// table for the main traffic patterns and hand-written redirect sequences.
module tb_instr_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
`ifdef IFB_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushes;
`endif

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_ready    (out_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .count        (count)
`ifdef IFB_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_flushes (stat_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        int          cycles;
        bit          do_reset;
        bit          req_rdy;
        bit          out_rdy;
        bit          redir;
        logic [31:0] redir_pc;
        int          lat;
        int          exp_acc;    // accepts expected in the phase, -1 = not checked
        int          exp_count;  // occupancy at phase end, -1 = not checked
    } phase_t;

    mreq_t       mq[$];
    ent_t        eq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          since_rst = 0;
    int          n_acc = 0;
    int          n_kept = 0;
    int          n_dropped = 0;
    int          n_redir = 0;
    int          n_pop = 0;
    int          first_acc = -1;
    int          first_pop = -1;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_pop_pc = 32'h0;
    logic [31:0] last_acc_addr = 32'h0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive the memory response, compare outputs against the
    // scoreboard just before the edge, then update the model after the edge.
    task automatic cycle();
        bit    exp_rv;
        bit    acc;
        bit    pop;
        bit    rsp;
        bit    redir_now;
        mreq_t r;
        if (!reset && mq.size() > 0 && mq[0].due <= cyc + 1) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = data_of(mq[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
        #1;
        if (!reset) begin
            exp_rv = (since_rst >= 1) && !redirect && (eq.size() + mq.size() < DEPTH);
            check("req_valid", {31'h0, mem_req_valid}, {31'h0, exp_rv});
            check("count", {29'h0, count}, eq.size());
            check("out_valid", {31'h0, out_valid}, {31'h0, eq.size() != 0});
            if (mem_req_valid) check("req_addr", mem_req_addr, exp_pc);
            if (out_valid && eq.size() > 0) begin
                check("out_pc", out_pc, eq[0].pc);
                check("out_instr", out_instr, eq[0].instr);
            end
        end
        acc       = mem_req_valid && mem_req_ready && !reset;
        pop       = out_valid && out_ready && !reset;
        rsp       = mem_rsp_valid;
        redir_now = redirect;
        @(posedge clk);
        cyc++;
        if (reset) begin
            mq.delete();
            eq.delete();
            exp_pc    = RESET_PC;
            since_rst = 0;
            n_acc     = 0;
            n_kept    = 0;
            n_dropped = 0;
            n_redir   = 0;
            first_acc = -1;
            first_pop = -1;
        end else begin
            since_rst++;
            if (pop && eq.size() > 0) begin
                last_pop_pc = eq[0].pc;
                if (first_pop < 0) first_pop = cyc;
                n_pop++;
                void'(eq.pop_front());
            end
            if (rsp && mq.size() > 0) begin
                r = mq.pop_front();
                if (!r.stale && !redir_now) begin
                    eq.push_back('{pc: r.addr, instr: data_of(r.addr)});
                    n_kept++;
                end else begin
                    n_dropped++;
                end
            end
            if (redir_now) begin
                eq.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                n_redir++;
            end else if (acc) begin
                mq.push_back('{addr: exp_pc, due: cyc + lat, stale: 1'b0});
                last_acc_addr = exp_pc;
                exp_pc        = exp_pc + 32'd4;
                n_acc++;
                if (first_acc < 0) first_acc = cyc;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        redirect = 1'b0;
        run(n);
        reset = 1'b0;
    endtask

    phase_t tbl[7];

    initial begin
        int acc0;
        int pop0;
        int budget;

        tbl[0] = '{cycles: 3,  do_reset: 1, req_rdy: 1, out_rdy: 1, redir: 0, redir_pc: 32'h0,         lat: 1, exp_acc: -1, exp_count: 0};
        tbl[1] = '{cycles: 12, do_reset: 0, req_rdy: 1, out_rdy: 1, redir: 0, redir_pc: 32'h0,         lat: 1, exp_acc: 11, exp_count: 1};
        tbl[2] = '{cycles: 5,  do_reset: 0, req_rdy: 0, out_rdy: 1, redir: 0, redir_pc: 32'h0,         lat: 1, exp_acc: 0,  exp_count: 0};
        tbl[3] = '{cycles: 2,  do_reset: 1, req_rdy: 1, out_rdy: 0, redir: 0, redir_pc: 32'h0,         lat: 1, exp_acc: -1, exp_count: 0};
        tbl[4] = '{cycles: 10, do_reset: 0, req_rdy: 1, out_rdy: 0, redir: 0, redir_pc: 32'h0,         lat: 1, exp_acc: 4,  exp_count: 4};
        tbl[5] = '{cycles: 6,  do_reset: 0, req_rdy: 1, out_rdy: 1, redir: 0, redir_pc: 32'h0,         lat: 1, exp_acc: -1, exp_count: -1};
        tbl[6] = '{cycles: 4,  do_reset: 0, req_rdy: 1, out_rdy: 1, redir: 1, redir_pc: 32'hFFFF_FFFC, lat: 1, exp_acc: 3,  exp_count: 1};

        reset         = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        out_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        @(negedge clk);

        // Phase table: reset, streaming, memory stall, backpressure, wrap redirect.
        for (int i = 0; i < 7; i++) begin
            reset         = tbl[i].do_reset;
            mem_req_ready = tbl[i].req_rdy;
            out_ready     = tbl[i].out_rdy;
            redirect_pc   = tbl[i].redir_pc;
            lat           = tbl[i].lat;
            acc0          = n_acc;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                redirect = tbl[i].redir && (c == 0);
                cycle();
            end
            redirect = 1'b0;
            if (tbl[i].do_reset) begin
                check($sformatf("rst_req_valid[%0d]", i), {31'h0, mem_req_valid}, 32'h0);
                check($sformatf("rst_out_valid[%0d]", i), {31'h0, out_valid}, 32'h0);
                check($sformatf("rst_out_instr[%0d]", i), out_instr, 32'h0);
                check($sformatf("rst_out_pc[%0d]", i), out_pc, 32'h0);
            end
            if (tbl[i].exp_acc >= 0)
                check($sformatf("phase_accepts[%0d]", i), n_acc - acc0, tbl[i].exp_acc);
            if (tbl[i].exp_count >= 0)
                check($sformatf("phase_count[%0d]", i), {29'h0, count}, tbl[i].exp_count);
            if (i == 1)
                check("first_pop_latency", first_pop - first_acc, 2);
        end
        reset = 1'b0;

        // Redirect to 0x100 with three requests in flight.
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        do_reset(2);
        lat = 4;
        run(4);
        check("inflight_before_redirect", mq.size(), 3);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        check("flush_count", {29'h0, count}, 32'h0);
        pop0   = n_pop;
        budget = 0;
        while (n_pop == pop0 && budget < 40) begin
            cycle();
            budget++;
        end
        check("redirect_pop_timeout", {31'h0, n_pop == pop0}, 32'h0);
        check("dropped_after_redirect", n_dropped, 3);
        check("first_pc_after_redirect", last_pop_pc, 32'h0000_0100);

        // Back-to-back redirects: the latest target wins; low address bits ignored.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect_pc = 32'h0000_0303;
        cycle();
        redirect = 1'b0;
        acc0   = n_acc;
        budget = 0;
        while (n_acc == acc0 && budget < 10) begin
            cycle();
            budget++;
        end
        check("b2b_first_req", last_acc_addr, 32'h0000_0300);
        pop0   = n_pop;
        budget = 0;
        while (n_pop == pop0 && budget < 40) begin
            cycle();
            budget++;
        end
        check("b2b_first_pop", last_pop_pc, 32'h0000_0300);

        // Two redirects and seven queued responses for the statistics counters.
        lat = 1;
        do_reset(2);
        run(6);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        cycle();
        redirect = 1'b0;
        run(3);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        cycle();
        redirect = 1'b0;
        budget   = 0;
        while (n_kept < 7 && budget < 50) begin
            cycle();
            budget++;
        end
        check("kept_responses", n_kept, 7);
`ifdef IFB_STATS_EN
        check("stat_flushes", stat_flushes, 32'd2);
        check("stat_fetched", stat_fetched, 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries and maximum in-flight requests (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have mem_req_valid, output, 1, fetch request to instruction memory.
REQ-006 SHALL have mem_req_addr, output, 32, byte address of the request.
REQ-007 SHALL have mem_req_ready, input, 1, memory accepts the request this cycle.
REQ-008 SHALL have mem_rsp_valid, input, 1, in-order instruction word returning.
REQ-009 SHALL have mem_rsp_data, input, 32, returned instruction.
REQ-010 SHALL have out_valid, output, 1, head entry available to the instruction register.
REQ-011 SHALL have out_instr, output, 32, head instruction.
REQ-012 SHALL have out_pc, output, 32, address of head instruction.
REQ-013 SHALL have out_ready, input, 1, consumer takes head this cycle.
REQ-014 SHALL have redirect, input, 1, flush and restart fetch (branch/jump resolved).
REQ-015 SHALL have redirect_pc, input, 32, new fetch address; bits [1:0] ignored and treated as zero.
REQ-016 SHALL have count, output, clog2(DEPTH)+1, current queue occupancy.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, DRAIN; IDLE -> FETCH unconditionally after one cycle; FETCH -> DRAIN on redirect with in-flight requests remaining; DRAIN -> FETCH when drop counter reaches 0; redirect in any state re-enters DRAIN or FETCH by the same rule.
REQ-018 SHALL drive mem_req_valid = (state != IDLE) && !redirect && (count + inflight < DEPTH); mem_req_addr = fetch_pc.
REQ-019 SHALL advance fetch_pc by 4 (modulo 2^32, wrapping FFFF_FFFC -> 0000_0000) on each cycle with mem_req_valid && mem_req_ready.
REQ-020 SHALL hold mem_req_addr stable while mem_req_valid is high and mem_req_ready low.
REQ-021 SHALL write mem_rsp_data and its request address into the queue tail when mem_rsp_valid and the drop counter is 0.
REQ-022 SHALL discard mem_rsp_valid responses while the drop counter is nonzero, decrementing it by 1 per discarded response.
REQ-023 SHALL drive out_valid = (count != 0), out_instr/out_pc from the head entry; pop on out_valid && out_ready; push and pop in the same cycle leave count unchanged.
REQ-024 SHALL never exceed count = DEPTH; credit rule REQ-018 guarantees space for every accepted request.
REQ-025 SHALL on redirect: complete any head pop that handshakes that cycle, flush all remaining entries (count = 0 next cycle), load fetch_pc = redirect_pc, discard any response arriving that cycle, load drop counter = in-flight requests remaining after that cycle's response.
REQ-026 SHALL give first request at redirect_pc on the cycle after redirect; back-to-back redirects use the latest redirect_pc.
REQ-027 SHALL give one-cycle latency from mem_rsp_valid to out_valid for an empty queue (no combinational bypass).

Reset
REQ-028 SHALL on reset: state = IDLE, fetch_pc = RESET_PC, count = 0, inflight = 0, drop counter = 0, mem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = 0.
REQ-029 SHALL let reset override redirect and all handshakes; responses to requests issued before reset are the memory's responsibility to cancel.

Configuration
REQ-030 SHALL, with IFB_STATS_EN defined, add outputs stat_fetched (32, count of queued responses) and stat_flushes (32, count of redirects), both zeroed by reset and wrapping at 2^32.
REQ-031 SHALL, without IFB_STATS_EN, omit those ports and counters entirely.

Verification
REQ-032 SHALL cover: reset release, mem_req_ready=1, 1-cycle response, out_ready=1 -> requests at 0,4,8,... ; out_pc 0 appears 2 cycles after first accept.
REQ-033 SHALL cover: out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, count=4, mem_req_valid=0 until first pop.
REQ-034 SHALL cover: redirect to 0x100 with 3 in flight -> count=0 next cycle, next 3 responses dropped, first out_pc=0x100.
REQ-035 SHALL cover: mem_req_ready=0 for 5 cycles -> mem_req_addr held constant, fetch_pc unchanged.
REQ-036 SHALL cover: redirect_pc=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-037 SHALL cover: with IFB_STATS_EN, 2 redirects and 7 queued responses -> stat_flushes=2, stat_fetched=7.
